crc_attach: RTL and testbench

Parametrised serial CRC attachment for the PUSCH transmit chain.
- Accepts a transport-block or code-block bit stream, MSB first, and passes each bit through with one cycle of latency.
- After the last message bit, appends the L-bit CRC remainder, MSB first.
- Supports the four NR polynomials (CRC16, CRC24A, CRC24B, CRC24C), selectable per block.
- Sits between the TB source and code-block segmentation; also usable as the CB-level CRC24B stage.

---
 rtl/crc_attach.sv | 156 +++++++++++++++
 tb/tb_crc_attach.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_attach.sv
// crc_attach: serial CRC attachment for the PUSCH transmit chain.
// Message bits pass through with one cycle of latency. After the last
// message bit, the L-bit remainder of the selected NR polynomial is
// appended MSB first. The four polynomials are CRC16, CRC24A, CRC24B and
// CRC24C.
// Optional feature macro: CRC_ATTACH_PARALLEL_OUT_EN. When it is defined,
// the crc_value and crc_done outputs are added, giving the remainder in
// parallel form.
//
// Handshake: an input bit transfers on a rising edge when
// in_valid && in_ready. A bit presented while in_ready is low is ignored,
// and the source must hold it until in_ready is high. The output side has
// no backpressure, so each cycle with out_valid high carries exactly one
// bit.
module crc_attach #(
   parameter logic [23:0] SEED         = 24'h000000,
   parameter logic [1:0]  MODE_DEFAULT = 2'd1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  crc_sel,
   input  logic        in_valid,
   input  logic        in_bit,
   input  logic        in_last,
   output logic        in_ready,
`ifdef CRC_ATTACH_PARALLEL_OUT_EN
   output logic [23:0] crc_value,
   output logic        crc_done,
`endif
   output logic        out_valid,
   output logic        out_bit,
   output logic        out_last,
   output logic        out_is_crc
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      APPEND = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  mode;
   logic [23:0] lfsr;
   logic [4:0]  cnt;

   // Generator polynomial without its implicit x^L term.
   function automatic logic [23:0] poly_of(input logic [1:0] m);
      case (m)
         2'd0:    poly_of = 24'h001021;
         2'd1:    poly_of = 24'h864CFB;
         2'd2:    poly_of = 24'h800063;
         default: poly_of = 24'hB2B117;
      endcase
   endfunction

   // CRC16 keeps the upper byte of the 24-bit register at zero.
   function automatic logic [23:0] mask_of(input logic [1:0] m);
      mask_of = (m == 2'd0) ? 24'h00FFFF : 24'hFFFFFF;
   endfunction

   // Bit L-1 of the register: the MSB of the remainder in the active mode.
   function automatic logic msb_of(input logic [23:0] cur, input logic [1:0] m);
      msb_of = (m == 2'd0) ? cur[15] : cur[23];
   endfunction

   // Index of the final parity bit, L-1.
   function automatic logic [4:0] last_idx(input logic [1:0] m);
      last_idx = (m == 2'd0) ? 5'd15 : 5'd23;
   endfunction

   // One Galois MSB-first step with message bit b.
   function automatic logic [23:0] crc_step(input logic [23:0] cur, input logic b,
                                            input logic [1:0] m);
      logic fb;
      fb       = b ^ msb_of(cur, m);
      crc_step = ({cur[22:0], 1'b0} ^ (fb ? poly_of(m) : 24'h000000)) & mask_of(m);
   endfunction

   // The source may push bits everywhere except while parity is being shifted out.
   assign in_ready = (state != APPEND);

   // Block FSM: mode latch, LFSR, parity counter and registered serial outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         mode       <= MODE_DEFAULT;
         lfsr       <= SEED;
         cnt        <= 5'd0;
         out_valid  <= 1'b0;
         out_bit    <= 1'b0;
         out_last   <= 1'b0;
         out_is_crc <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         out_bit    <= 1'b0;
         out_last   <= 1'b0;
         out_is_crc <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // The first bit fixes the block mode and starts from SEED.
                  mode      <= crc_sel;
                  lfsr      <= crc_step(SEED & mask_of(crc_sel), in_bit, crc_sel);
                  cnt       <= 5'd0;
                  out_valid <= 1'b1;
                  out_bit   <= in_bit;
                  state     <= in_last ? APPEND : DATA;
               end
            end
            DATA: begin
               if (in_valid) begin
                  lfsr      <= crc_step(lfsr, in_bit, mode);
                  out_valid <= 1'b1;
                  out_bit   <= in_bit;
                  if (in_last) begin
                     cnt   <= 5'd0;
                     state <= APPEND;
                  end
               end
            end
            APPEND: begin
               out_valid  <= 1'b1;
               out_is_crc <= 1'b1;
               out_bit    <= msb_of(lfsr, mode);
               lfsr       <= {lfsr[22:0], 1'b0} & mask_of(mode);
               if (cnt == last_idx(mode)) begin
                  out_last <= 1'b1;
                  cnt      <= 5'd0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CRC_ATTACH_PARALLEL_OUT_EN
   // Capture the complete remainder alongside the first parity bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         crc_value <= 24'h000000;
         crc_done  <= 1'b0;
      end else begin
         crc_done <= 1'b0;
         if (state == APPEND && cnt == 5'd0) begin
            crc_value <= lfsr & mask_of(mode);
            crc_done  <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_crc_attach.sv
// tb_crc_attach: randomized self-checking bench for crc_attach.
// The reference CRC is computed by polynomial long division over the
// message, using SEED = 0. A scoreboard queue holds the expected serial
// beats.
// Optional macro: CRC_ATTACH_PARALLEL_OUT_EN, which also checks crc_value
// and crc_done.
module tb_crc_attach;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [1:0]  crc_sel = 2'd0;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_bit;
   logic        out_last;
   logic        out_is_crc;
`ifdef CRC_ATTACH_PARALLEL_OUT_EN
   logic [23:0] crc_value;
   logic        crc_done;
   logic [23:0] exp_cv[$];
   logic        done_prev = 1'b0;
   logic        last_was_crc = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard entries are {is_crc, last, bit}.
   logic [2:0]  exp_q[$];
   logic        msg_q[$];
   logic        mon_en = 1'b0;
   logic        prev_acc = 1'b0;
   logic        seen_out = 1'b0;
   int          gap_cnt = 0;
   int          crc_cnt = 0;

   crc_attach dut (
      .CLK        (CLK),
      .RST        (RST),
      .crc_sel    (crc_sel),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_last    (in_last),
      .in_ready   (in_ready),
`ifdef CRC_ATTACH_PARALLEL_OUT_EN
      .crc_value  (crc_value),
      .crc_done   (crc_done),
`endif
      .out_valid  (out_valid),
      .out_bit    (out_bit),
      .out_last   (out_last),
      .out_is_crc (out_is_crc)
   );

   // Clock and watchdog.
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference remainder of msg_q * x^L modulo the generator polynomial.
   function automatic logic [23:0] ref_crc(input logic [1:0] mode);
      int          len;
      int          n;
      logic [23:0] poly;
      logic [23:0] res;
      logic        w[$];
      len  = (mode == 2'd0) ? 16 : 24;
      poly = (mode == 2'd0) ? 24'h001021 : (mode == 2'd1) ? 24'h864CFB :
             (mode == 2'd2) ? 24'h800063 : 24'hB2B117;
      n    = msg_q.size();
      w    = msg_q;
      for (int j = 0; j < len; j++) w.push_back(1'b0);
      for (int i = 0; i < n; i++)
         if (w[i])
            for (int j = 0; j < len; j++) w[i+1+j] = w[i+1+j] ^ poly[len-1-j];
      res = 24'h0;
      for (int j = 0; j < len; j++) res = {res[22:0], w[n+j]};
      return res;
   endfunction

   // Monitor: compare each output cycle against the scoreboard.
   always @(negedge CLK) begin
      logic [3:0] exp_beat;
      logic       exp_v;
      if (mon_en) begin
         exp_v = (exp_q.size() > 0 && exp_q[0][2]) ? 1'b1 : prev_acc;
         check("out_valid", out_valid, exp_v);
`ifdef CRC_ATTACH_PARALLEL_OUT_EN
         if (crc_done) begin
            check("crc_done_timing", {out_is_crc, last_was_crc}, 2'b10);
            check("crc_value", crc_value,
                  (exp_cv.size() > 0) ? {8'h0, exp_cv.pop_front()} : 32'hFFFFFFFF);
         end
         check("crc_done_pulse", crc_done && done_prev, 0);
`endif
         if (out_valid) begin
            seen_out = 1'b1;
            if (out_is_crc) crc_cnt++;
            exp_beat = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 4'b0000;
            check("beat", {1'b1, out_is_crc, out_last, out_bit}, exp_beat);
         end else if (seen_out && exp_q.size() > 0) begin
            gap_cnt++;
         end
      end
`ifdef CRC_ATTACH_PARALLEL_OUT_EN
      done_prev    = crc_done;
      last_was_crc = out_valid && out_is_crc;
`endif
      prev_acc = in_valid && in_ready && !RST;
   end

   // Driver: present one bit and hold it until it transfers.
   task automatic drive_bit(input logic b, input logic last, input logic [1:0] sel);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = last;
      crc_sel  = sel;
      while (!in_ready && guard < 200) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Queue the expected stream for msg_q, then drive it.
   // crc_sel switches to sw_sel from bit index sw_idx onward.
   task automatic send_block(input logic [1:0] mode, input logic [23:0] parity,
                             input int gap_max, input int sw_idx, input logic [1:0] sw_sel);
      int len;
      int n;
      len = (mode == 2'd0) ? 16 : 24;
      n   = msg_q.size();
      for (int i = 0; i < n; i++) exp_q.push_back({2'b00, msg_q[i]});
      for (int i = 0; i < len; i++)
         exp_q.push_back({1'b1, (i == len - 1), parity[len-1-i]});
`ifdef CRC_ATTACH_PARALLEL_OUT_EN
      exp_cv.push_back(parity);
`endif
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) begin @(posedge CLK); #1; end
         drive_bit(msg_q[i], (i == n - 1), (i >= sw_idx) ? sw_sel : mode);
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 500) begin
         @(posedge CLK); #1;
         guard++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // Test sequence.
   initial begin
      logic [23:0] single_par[4];
      int          rdy_low;
      int          len;
      logic [1:0]  m;
      string       s;
      byte         ch;
      single_par[0] = 24'h001021;
      single_par[1] = 24'h864CFB;
      single_par[2] = 24'h800063;
      single_par[3] = 24'hB2B117;

      // Reset state.
      repeat (3) @(posedge CLK);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_bit", out_bit, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_is_crc", out_is_crc, 0);
      check("rst_in_ready", in_ready, 1);
      RST = 1'b0;
      @(posedge CLK); #1;
      mon_en = 1'b1;

      // CRC16 single bit, counting the in_ready low cycles.
      crc_cnt = 0;
      msg_q   = '{1'b1};
      send_block(2'd0, single_par[0], 0, 99, 2'd0);
      rdy_low = 0;
      for (int i = 0; i < 20; i++) begin
         if (!in_ready) rdy_low++;
         @(posedge CLK); #1;
      end
      check("crc16_ready_low", rdy_low, 16);
      wait_drain();
      check("crc16_is_crc_cnt", crc_cnt, 16);

      // Single bit, 24-bit modes.
      for (int md = 1; md < 4; md++) begin
         crc_cnt = 0;
         msg_q   = '{1'b1};
         send_block(md[1:0], single_par[md], 0, 99, 2'd0);
         wait_drain();
         check("crc24_is_crc_cnt", crc_cnt, 24);
      end

      // Known vector "123456789" in CRC16, with random input gaps.
      s = "123456789";
      msg_q.delete();
      for (int i = 0; i < 9; i++) begin
         ch = s[i];
         for (int b = 7; b >= 0; b--) msg_q.push_back(ch[b]);
      end
      send_block(2'd0, 24'h0031C3, 3, 999, 2'd0);
      wait_drain();

      // Back-to-back: CRC24A with 40 zeros and crc_sel changed mid-block, then CRC16 '1'.
      seen_out = 1'b0;
      gap_cnt  = 0;
      msg_q.delete();
      for (int i = 0; i < 40; i++) msg_q.push_back(1'b0);
      send_block(2'd1, 24'h000000, 0, 20, 2'd0);
      msg_q = '{1'b1};
      send_block(2'd0, single_par[0], 0, 99, 2'd0);
      wait_drain();
      check("b2b_gap_cnt", gap_cnt, 0);

      // Reset during APPEND, after the 5th parity bit.
      mon_en = 1'b0;
      exp_q.delete();
      drive_bit(1'b1, 1'b1, 2'd1);
      repeat (4) begin @(posedge CLK); #1; end
      check("mid_append_is_crc", out_is_crc, 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("abort_out_valid", out_valid, 0);
      check("abort_out_bit", out_bit, 0);
      check("abort_out_is_crc", out_is_crc, 0);
      check("abort_in_ready", in_ready, 1);
      mon_en = 1'b1;
      msg_q  = '{1'b1};
      send_block(2'd0, single_par[0], 0, 99, 2'd0);
      wait_drain();

      // Random blocks checked against the long-division model.
      for (int t = 0; t < 8; t++) begin
         m   = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 48);
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom_range(0, 1)));
         send_block(m, ref_crc(m), 2, $urandom_range(0, 60), 2'($urandom_range(0, 3)));
      end
      wait_drain();

`ifdef CRC_ATTACH_PARALLEL_OUT_EN
      check("crc_done_count", exp_cv.size(), 0);
`endif
      repeat (3) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
